// File: rtl/seg6_pkg.sv
// Shared types and constants for the six-digit seven-segment scanner.
package seg6_pkg;

  localparam int N_DIGITS = 6;

  typedef logic [3:0] nibble_t;

  // Active-high g..a patterns for hex 0..F
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low g..a segment decoder.
module seg7_decode
  import seg6_pkg::*;
(
  input  nibble_t    nib,
  output logic [6:0] seg_n
);

  assign seg_n = ~SEG_LUT[nib];

endmodule

// File: rtl/seg6_scan.sv
// Six-digit multiplexed display driver: frame-latched shadow value,
// per-slot dead-time blanking and optional leading-zero suppression.
module seg6_scan
  import seg6_pkg::*;
#(
  parameter int DIV   = 50000,
  parameter int BLANK = 500,
  parameter bit LZB   = 1'b1
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [23:0] value,
  input  logic [5:0]  dp,
  output logic [7:0]  seg_n,
  output logic [5:0]  dig_n
);

  localparam int CNT_W = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK);
  localparam logic [2:0]       IDX_MAX   = 3'(N_DIGITS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [23:0]      shadow_v_q, shadow_v_d;
  logic [5:0]       shadow_dp_q, shadow_dp_d;
  logic [7:0]       seg_n_q, seg_n_d;
  logic [5:0]       dig_n_q, dig_n_d;

  logic             slot_end;
  logic             frame_end;
  logic [5:0]       lz_dark;
  nibble_t          cur_nib;
  logic [6:0]       cur_seg_n;

  always_comb begin
    slot_end    = (cnt_q == CNT_MAX);
    frame_end   = slot_end && (idx_q == IDX_MAX);
    cnt_d       = slot_end ? '0 : cnt_q + CNT_W'(1);
    idx_d       = idx_q;
    shadow_v_d  = shadow_v_q;
    shadow_dp_d = shadow_dp_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_MAX) ? 3'd0 : idx_q + 3'd1;
    end
    // Latch only between frames so a digit never mixes old and new data
    if (frame_end) begin
      shadow_v_d  = value;
      shadow_dp_d = dp;
    end
  end

  // Digit k is dark when it and every more-significant nibble are zero
  always_comb begin
    lz_dark = '0;
    for (int k = 1; k < N_DIGITS; k++) begin
      lz_dark[k] = LZB && ((shadow_v_q >> (4 * k)) == 24'd0);
    end
  end

  assign cur_nib = shadow_v_q[{idx_q, 2'b00} +: 4];

  seg7_decode u_decode (
    .nib   (cur_nib),
    .seg_n (cur_seg_n)
  );

  always_comb begin
    seg_n_d = 8'hFF;
    dig_n_d = 6'h3F;
    if (cnt_q >= CNT_BLANK) begin
      seg_n_d = {~shadow_dp_q[idx_q], cur_seg_n};
      if (!lz_dark[idx_q]) begin
        dig_n_d = ~(6'b000001 << idx_q);
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      shadow_v_q  <= '0;
      shadow_dp_q <= '0;
      seg_n_q     <= 8'hFF;
      dig_n_q     <= 6'h3F;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shadow_v_q  <= shadow_v_d;
      shadow_dp_q <= shadow_dp_d;
      seg_n_q     <= seg_n_d;
      dig_n_q     <= dig_n_d;
    end
  end

  assign seg_n = seg_n_q;
  assign dig_n = dig_n_q;

endmodule

// File: tb/tb_seg6_scan.sv
// Self-checking bench for seg6_scan: directed and random values checked every
// cycle against a frame-level reference model, with and without zero blanking.
module tb_seg6_scan;

  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = 6 * DIV;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic [23:0] value;
  logic [5:0]  dp;
  logic [7:0]  seg_n_a, seg_n_b;
  logic [5:0]  dig_n_a, dig_n_b;

  int checks   = 0;
  int failures = 0;

  int          n;
  logic [23:0] m_sv;
  logic [5:0]  m_sdp;
  int          run;
  bit          seen_lit;

  logic [6:0] lut [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  always #5 clk_clk = ~clk_clk;

  seg6_scan #(.DIV(DIV), .BLANK(BLANK), .LZB(1'b1)) u_lzb (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .value         (value),
    .dp            (dp),
    .seg_n         (seg_n_a),
    .dig_n         (dig_n_a)
  );

  seg6_scan #(.DIV(DIV), .BLANK(BLANK), .LZB(1'b0)) u_nolz (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .value         (value),
    .dp            (dp),
    .seg_n         (seg_n_b),
    .dig_n         (dig_n_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h edge=%0d t=%0t", tag, got, exp, n, $time);
    end
  endtask

  // Expected {seg_n, dig_n} for one slot position given the latched frame data
  function automatic logic [13:0] model_out(input logic [23:0] sv, input logic [5:0] sdp,
                                            input int cnt, input int idx, input bit lzb);
    logic [3:0] nib;
    bit         dark;
    logic [7:0] seg;
    logic [5:0] dig;
    if (cnt < BLANK) return {8'hFF, 6'h3F};
    nib  = 4'((sv >> (4 * idx)) & 24'hF);
    dark = lzb && (idx > 0) && ((sv >> (4 * idx)) == 24'd0);
    seg  = {~sdp[idx], ~lut[nib]};
    dig  = dark ? 6'h3F : 6'(~(32'd1 << idx));
    return {seg, dig};
  endfunction

  task automatic model_reset();
    n        = 0;
    m_sv     = '0;
    m_sdp    = '0;
    run      = 0;
    seen_lit = 1'b0;
  endtask

  task automatic step();
    logic [23:0] vin;
    logic [5:0]  dpin;
    int          cnt, idx;
    logic [13:0] ea, eb;
    vin  = value;
    dpin = dp;
    @(posedge clk_clk);
    #1;
    cnt = n % DIV;
    idx = (n / DIV) % 6;
    ea  = model_out(m_sv, m_sdp, cnt, idx, 1'b1);
    eb  = model_out(m_sv, m_sdp, cnt, idx, 1'b0);
    chk("seg_lzb",  seg_n_a, ea[13:6]);
    chk("dig_lzb",  dig_n_a, ea[5:0]);
    chk("seg_nolz", seg_n_b, eb[13:6]);
    chk("dig_nolz", dig_n_b, eb[5:0]);
    chk("onehot_lzb",  ($countones(~dig_n_a) <= 1), 1);
    chk("onehot_nolz", ($countones(~dig_n_b) <= 1), 1);
    if (dig_n_b == 6'h3F) begin
      run++;
    end else begin
      if (seen_lit && run > 0) chk("dead_time", run, BLANK);
      seen_lit = 1'b1;
      run      = 0;
    end
    if (cnt == DIV - 1 && idx == 5) begin
      m_sv  = vin;
      m_sdp = dpin;
    end
    n++;
  endtask

  task automatic do_reset();
    reset_reset_n = 1'b0;
    #2;
    chk("rst_seg_lzb",  seg_n_a, 8'hFF);
    chk("rst_dig_lzb",  dig_n_a, 6'h3F);
    chk("rst_seg_nolz", seg_n_b, 8'hFF);
    chk("rst_dig_nolz", dig_n_b, 6'h3F);
    @(posedge clk_clk);
    #1;
    reset_reset_n = 1'b1;
    model_reset();
  endtask

  task automatic wait_slot(input int target);
    bit found = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (((n / DIV) % 6) == target && (n % DIV) == 0) begin
        found = 1'b1;
        break;
      end
      step();
    end
    if (!found) chk("wait_slot_timeout", 0, 1);
  endtask

  initial begin
    reset_reset_n = 1'b0;
    value         = '0;
    dp            = '0;
    model_reset();
    repeat (2) @(posedge clk_clk);
    #1;
    chk("por_seg", seg_n_a, 8'hFF);
    chk("por_dig", dig_n_a, 6'h3F);
    reset_reset_n = 1'b1;

    // Power-up frame shows a lone "0", then reset in the middle of a slot
    repeat (DIV + 4) step();
    do_reset();

    value = 24'h123456;
    repeat (2 * FRAME) step();

    value = 24'h000A05;
    repeat (2 * FRAME) step();

    // Change mid-frame: the rest of this frame must keep the old digits
    value = 24'h111111;
    wait_slot(0);
    wait_slot(2);
    value = 24'h222222;
    repeat (2 * FRAME) step();

    value = 24'h000000;
    dp    = 6'b000001;
    repeat (2 * FRAME) step();
    dp    = 6'b100000;
    repeat (2 * FRAME) step();

    for (int it = 0; it < 40; it++) begin
      value = 24'($urandom) >> (4 * $urandom_range(0, 6));
      dp    = 6'($urandom);
      repeat ($urandom_range(1, 70)) step();
      if (it == 20) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
